// File: rtl/collision_ctl.sv
// Wall/hero collision scanner: walks an external wall ROM once per start pulse and
// publishes an 8-bit probe-hit vector. Define HERO_OVERLAP_EN to also test heroes against each other.
module collision_ctl #(
    parameter int NUM_WALLS   = 32,
    parameter int ADDR_W      = 5,
    parameter int SQUARE_SIDE = 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [23:0]       x_pos,
    input  logic [23:0]       y_pos,
    output logic [ADDR_W-1:0] wall_addr,
    input  logic [47:0]       wall_data,
    output logic [7:0]        collision,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HERO = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WALLS - 1);
    localparam logic [12:0]       SIDE      = 13'(SQUARE_SIDE);
    localparam logic [12:0]       SIDE_M1   = 13'(SQUARE_SIDE - 1);

    // Inclusive interval intersection on 13-bit unsigned coordinates.
    function automatic logic span_overlap(input logic [12:0] a0, input logic [12:0] a1,
                                          input logic [12:0] b0, input logic [12:0] b1);
        return (a0 <= b1) && (b0 <= a1);
    endfunction

    // Bits: 0 left, 1 right, 2 down, 3 up, each a 1-pixel strip around the SxS square at (x,y).
    function automatic logic [3:0] probe_hits(input logic [11:0] x, input logic [11:0] y,
                                              input logic [12:0] rx0, input logic [12:0] rx1,
                                              input logic [12:0] ry0, input logic [12:0] ry1);
        logic [12:0] xe;
        logic [12:0] ye;
        logic [12:0] x_left;
        logic [12:0] x_right;
        logic [12:0] x_end;
        logic [12:0] y_up;
        logic [12:0] y_down;
        logic [12:0] y_end;
        logic [3:0]  h;
        xe      = {1'b0, x};
        ye      = {1'b0, y};
        x_left  = xe - 13'd1;
        x_right = xe + SIDE;
        x_end   = xe + SIDE_M1;
        y_up    = ye - 13'd1;
        y_down  = ye + SIDE;
        y_end   = ye + SIDE_M1;
        h[0] = span_overlap(x_left, x_left, rx0, rx1) && span_overlap(ye, y_end, ry0, ry1);
        h[1] = span_overlap(x_right, x_right, rx0, rx1) && span_overlap(ye, y_end, ry0, ry1);
        h[2] = span_overlap(xe, x_end, rx0, rx1) && span_overlap(y_down, y_down, ry0, ry1);
        h[3] = span_overlap(xe, x_end, rx0, rx1) && span_overlap(y_up, y_up, ry0, ry1);
        return h;
    endfunction

    state_e            state_q, state_d;
    logic [23:0]       snap_x_q, snap_x_d;
    logic [23:0]       snap_y_q, snap_y_d;
    logic [7:0]        acc_q, acc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              issued_all_q, issued_all_d;
    logic              data_vld_q, data_vld_d;
    logic              data_last_q, data_last_d;
    logic [7:0]        coll_q, coll_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [11:0] x0, y0, x1, y1;
    logic [12:0] wx, wy, ww, wh, wx_end, wy_end;
    logic        wall_empty;
    logic [7:0]  wall_hits;
    logic [7:0]  edge_hits;
    logic        addr_vld;

    assign x0 = snap_x_q[11:0];
    assign x1 = snap_x_q[23:12];
    assign y0 = snap_y_q[11:0];
    assign y1 = snap_y_q[23:12];

    assign wx         = {1'b0, wall_data[47:36]};
    assign wy         = {1'b0, wall_data[35:24]};
    assign ww         = {1'b0, wall_data[23:12]};
    assign wh         = {1'b0, wall_data[11:0]};
    assign wx_end     = wx + ww - 13'd1;
    assign wy_end     = wy + wh - 13'd1;
    assign wall_empty = (ww == 13'd0) || (wh == 13'd0);
    assign wall_hits  = wall_empty ? 8'h00 :
                        {probe_hits(x1, y1, wx, wx_end, wy, wy_end),
                         probe_hits(x0, y0, wx, wx_end, wy, wy_end)};

    // Screen borders block the left/up probes of a hero sitting on them.
    assign edge_hits = {(y1 == 12'd0), 2'b00, (x1 == 12'd0),
                        (y0 == 12'd0), 2'b00, (x0 == 12'd0)};

`ifdef HERO_OVERLAP_EN
    logic [12:0] x0e, y0e, x1e, y1e;
    logic [7:0]  hero_hits;
    assign x0e = {1'b0, x0};
    assign y0e = {1'b0, y0};
    assign x1e = {1'b0, x1};
    assign y1e = {1'b0, y1};
    assign hero_hits = {probe_hits(x1, y1, x0e, x0e + SIDE_M1, y0e, y0e + SIDE_M1),
                        probe_hits(x0, y0, x1e, x1e + SIDE_M1, y1e, y1e + SIDE_M1)};
`endif

    // An address is in flight while scanning until the last index has been issued;
    // the ROM answers one cycle later, tracked by data_vld_q/data_last_q.
    assign addr_vld = (state_q == SCAN) && !issued_all_q;

    // start is only sampled in IDLE (no queueing); done is a single-cycle pulse
    // on the edge collision is updated, and busy covers E0 up to that edge.
    always_comb begin
        state_d      = state_q;
        snap_x_d     = snap_x_q;
        snap_y_d     = snap_y_q;
        acc_d        = acc_q;
        addr_d       = addr_q;
        issued_all_d = issued_all_q;
        data_vld_d   = 1'b0;
        data_last_d  = 1'b0;
        coll_d       = coll_q;
        done_d       = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_x_d     = x_pos;
                    snap_y_d     = y_pos;
                    acc_d        = 8'h00;
                    addr_d       = '0;
                    issued_all_d = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                if (addr_vld) begin
                    data_vld_d  = 1'b1;
                    data_last_d = (addr_q == LAST_ADDR);
                    if (addr_q == LAST_ADDR) begin
                        issued_all_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                if (data_vld_q) begin
                    acc_d = acc_q | wall_hits;
                    if (data_last_q) begin
`ifdef HERO_OVERLAP_EN
                        state_d = HERO;
`else
                        coll_d  = acc_q | wall_hits | edge_hits;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef HERO_OVERLAP_EN
            HERO: begin
                coll_d  = acc_q | hero_hits | edge_hits;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            acc_q        <= '0;
            addr_q       <= '0;
            issued_all_q <= 1'b0;
            data_vld_q   <= 1'b0;
            data_last_q  <= 1'b0;
            coll_q       <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_x_q     <= snap_x_d;
            snap_y_q     <= snap_y_d;
            acc_q        <= acc_d;
            addr_q       <= addr_d;
            issued_all_q <= issued_all_d;
            data_vld_q   <= data_vld_d;
            data_last_q  <= data_last_d;
            coll_q       <= coll_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign wall_addr = addr_q;
    assign collision = coll_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule
